cp0_exc_seq: RTL and testbench
==============================

CP0_EXC_SEQ -- requirements
Module: cp0_exc_seq

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h00400004, exception handler entry address.
REQ-002 SHALL have ports: CLK  in  1  single clock, all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 EXC_REQ  in  1  exception request, level-sampled in IDLE; EXC_CODE  in  5  cause code (syscall 8, break 9, teq 13).
REQ-005 ERET_REQ  in  1  return-from-exception request, sampled in IDLE.
REQ-006 PC_IN  in  32  address of the excepting instruction; STATUS_IN  in  32  current CP0 Status; EPC_IN  in  32  current CP0 EPC.
REQ-007 MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC, MUXT_CP0_W_STATUS  out  1 each  CP0 write-address selects to the downstream address mux.
REQ-008 CP0_WE  out  1  CP0 write enable; CP0_WDATA  out  32  CP0 write data.
REQ-009 PC_REDIRECT  out  1  one-cycle PC-load pulse; PC_TARGET  out  32  new PC, valid while PC_REDIRECT=1.
REQ-010 BUSY  out  1  high in every non-IDLE state.

Function
REQ-011 SHALL implement FSM states IDLE, X_STATUS, X_CAUSE, X_EPC, X_JUMP, R_STATUS, R_JUMP.
REQ-012 In IDLE, an accepted EXC_REQ SHALL latch EXC_CODE, PC_IN, STATUS_IN and go to X_STATUS on the next edge.
REQ-013 In IDLE with ERET_REQ=1 and EXC_REQ=0, SHALL latch STATUS_IN and EPC_IN and go to R_STATUS.
REQ-014 EXC_REQ and ERET_REQ high together in IDLE: exception SHALL win; ERET dropped.
REQ-015 Requests arriving while BUSY=1 SHALL be ignored, not queued.
REQ-016 Exception path SHALL advance X_STATUS->X_CAUSE->X_EPC->X_JUMP->IDLE, one cycle each; ERET path R_STATUS->R_JUMP->IDLE.
REQ-017 X_STATUS: MUXT_CP0_W_STATUS=1, CP0_WE=1, CP0_WDATA = latched Status << 5 (zero fill, 32-bit truncate).
REQ-018 X_CAUSE: MUXT_CP0_W_CAUSE=1, CP0_WE=1, CP0_WDATA = {25'b0, code, 2'b00}.
REQ-019 X_EPC: MUXT_CP0_W_EPC=1, CP0_WE=1, CP0_WDATA = latched PC.
REQ-020 R_STATUS: MUXT_CP0_W_STATUS=1, CP0_WE=1, CP0_WDATA = latched Status >> 5 (logical).
REQ-021 X_JUMP: PC_REDIRECT=1, PC_TARGET=EXC_VECTOR; R_JUMP: PC_REDIRECT=1, PC_TARGET=latched EPC; CP0_WE=0 in both.
REQ-022 At most one MUXT_* select SHALL be high in any cycle; all selects, CP0_WE, PC_REDIRECT SHALL be 0 in IDLE.
REQ-023 Exception latency: first CP0 write 1 cycle after accept edge, PC_REDIRECT 4 cycles after; ERET: write at 1, redirect at 2.
REQ-024 CP0_WDATA and PC_TARGET SHALL be 0 whenever CP0_WE resp. PC_REDIRECT is 0.

Reset
REQ-025 RST=1 SHALL immediately force IDLE, clear latched code/PC/Status/EPC, and drive all outputs to 0, independent of CLK.
REQ-026 Reset mid-sequence SHALL abort it; no further CP0 write or redirect from that sequence after RST deasserts.

Configuration
REQ-027 Macro CP0_EXC_MASK_EN: when defined, EXC_REQ SHALL be accepted only if STATUS_IN[0]=1 and the code's mask bit is 1 (syscall bit 1, break bit 2, teq bit 3); masked requests leave FSM in IDLE with no outputs; unlisted codes are always masked.
REQ-028 Without CP0_EXC_MASK_EN, every EXC_REQ in IDLE SHALL be accepted regardless of STATUS_IN.

Verification
REQ-029 Syscall: EXC_REQ=1, code 8, PC_IN=32'h00400020, STATUS_IN=32'h0000000F -> writes 32'h000001E0 (Status), 32'h00000020 (Cause), 32'h00400020 (EPC) on cycles 1-3; cycle 4 PC_TARGET=32'h00400004.
REQ-030 ERET: STATUS_IN=32'h000001E0, EPC_IN=32'h00400020 -> cycle 1 Status write 32'h0000000F; cycle 2 PC_TARGET=32'h00400024 must not appear, PC_TARGET=32'h00400020.
REQ-031 EXC_REQ and ERET_REQ same cycle -> exception sequence only; second EXC_REQ during BUSY ignored.
REQ-032 RST pulse during X_CAUSE -> outputs 0 immediately, BUSY=0, no EPC write or redirect follows.
REQ-033 With CP0_EXC_MASK_EN, STATUS_IN=32'h0000000D, code 8 -> no write, BUSY stays 0; code 9 -> full sequence.

Source files
------------

// File: rtl/cp0_exc_seq.sv
// CP0 exception/ERET sequencer: writes Status/Cause/EPC then redirects the PC (exception 4 cycles, ERET 2).
// No backpressure: requests are sampled only in IDLE and dropped while BUSY; CP0_EXC_MASK_EN gates acceptance on Status.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXC_REQ,
  input  logic [4:0]  EXC_CODE,
  input  logic        ERET_REQ,
  input  logic [31:0] PC_IN,
  input  logic [31:0] STATUS_IN,
  input  logic [31:0] EPC_IN,
  output logic        MUXT_CP0_W_CAUSE,
  output logic        MUXT_CP0_W_EPC,
  output logic        MUXT_CP0_W_STATUS,
  output logic        CP0_WE,
  output logic [31:0] CP0_WDATA,
  output logic        PC_REDIRECT,
  output logic [31:0] PC_TARGET,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    X_STATUS = 3'd1,
    X_CAUSE  = 3'd2,
    X_EPC    = 3'd3,
    X_JUMP   = 3'd4,
    R_STATUS = 3'd5,
    R_JUMP   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic        w_exc_ok;
  logic        w_exc_acc;
  logic        w_eret_acc;

`ifdef CP0_EXC_MASK_EN
  // Global enable in Status[0]; per-cause enables in Status[3:1]; anything else stays masked.
  always_comb begin
    w_exc_ok = 1'b0;
    case (EXC_CODE)
      5'd8:    w_exc_ok = STATUS_IN[1];
      5'd9:    w_exc_ok = STATUS_IN[2];
      5'd13:   w_exc_ok = STATUS_IN[3];
      default: w_exc_ok = 1'b0;
    endcase
    w_exc_ok = w_exc_ok & STATUS_IN[0];
  end
`else
  assign w_exc_ok = 1'b1;
`endif

  assign w_exc_acc  = (r_state == IDLE) && EXC_REQ && w_exc_ok;
  // A raised EXC_REQ suppresses ERET even when the exception itself is masked.
  assign w_eret_acc = (r_state == IDLE) && ERET_REQ && !EXC_REQ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_code   <= 5'd0;
      r_pc     <= 32'd0;
      r_status <= 32'd0;
      r_epc    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exc_acc) begin
        r_code   <= EXC_CODE;
        r_pc     <= PC_IN;
        r_status <= STATUS_IN;
      end else if (w_eret_acc) begin
        r_status <= STATUS_IN;
        r_epc    <= EPC_IN;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    MUXT_CP0_W_CAUSE  = 1'b0;
    MUXT_CP0_W_EPC    = 1'b0;
    MUXT_CP0_W_STATUS = 1'b0;
    CP0_WE            = 1'b0;
    CP0_WDATA         = 32'd0;
    PC_REDIRECT       = 1'b0;
    PC_TARGET         = 32'd0;
    BUSY              = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_exc_acc)
          w_state_nxt = X_STATUS;
        else if (w_eret_acc)
          w_state_nxt = R_STATUS;
      end
      X_STATUS: begin
        MUXT_CP0_W_STATUS = 1'b1;
        CP0_WE            = 1'b1;
        CP0_WDATA         = r_status << 5;
        w_state_nxt       = X_CAUSE;
      end
      X_CAUSE: begin
        MUXT_CP0_W_CAUSE = 1'b1;
        CP0_WE           = 1'b1;
        CP0_WDATA        = {25'd0, r_code, 2'b00};
        w_state_nxt      = X_EPC;
      end
      X_EPC: begin
        MUXT_CP0_W_EPC = 1'b1;
        CP0_WE         = 1'b1;
        CP0_WDATA      = r_pc;
        w_state_nxt    = X_JUMP;
      end
      X_JUMP: begin
        PC_REDIRECT = 1'b1;
        PC_TARGET   = EXC_VECTOR;
        w_state_nxt = IDLE;
      end
      R_STATUS: begin
        MUXT_CP0_W_STATUS = 1'b1;
        CP0_WE            = 1'b1;
        CP0_WDATA         = r_status >> 5;
        w_state_nxt       = R_JUMP;
      end
      R_JUMP: begin
        PC_REDIRECT = 1'b1;
        PC_TARGET   = r_epc;
        w_state_nxt = IDLE;
      end
      default: begin
        BUSY        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for cp0_exc_seq: expected per-cycle outputs are queued ahead of each step and checked on the falling edge.
module tb_cp0_exc_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EXC_REQ;
  logic [4:0]  EXC_CODE;
  logic        ERET_REQ;
  logic [31:0] PC_IN;
  logic [31:0] STATUS_IN;
  logic [31:0] EPC_IN;
  logic        MUXT_CP0_W_CAUSE;
  logic        MUXT_CP0_W_EPC;
  logic        MUXT_CP0_W_STATUS;
  logic        CP0_WE;
  logic [31:0] CP0_WDATA;
  logic        PC_REDIRECT;
  logic [31:0] PC_TARGET;
  logic        BUSY;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b100;
  localparam logic [2:0] SEL_C    = 3'b010;
  localparam logic [2:0] SEL_E    = 3'b001;
  localparam logic [31:0] VEC     = 32'h00400004;

  always #5 CLK = ~CLK;

  cp0_exc_seq dut (
    .CLK              (CLK),
    .RST              (RST),
    .EXC_REQ          (EXC_REQ),
    .EXC_CODE         (EXC_CODE),
    .ERET_REQ         (ERET_REQ),
    .PC_IN            (PC_IN),
    .STATUS_IN        (STATUS_IN),
    .EPC_IN           (EPC_IN),
    .MUXT_CP0_W_CAUSE (MUXT_CP0_W_CAUSE),
    .MUXT_CP0_W_EPC   (MUXT_CP0_W_EPC),
    .MUXT_CP0_W_STATUS(MUXT_CP0_W_STATUS),
    .CP0_WE           (CP0_WE),
    .CP0_WDATA        (CP0_WDATA),
    .PC_REDIRECT      (PC_REDIRECT),
    .PC_TARGET        (PC_TARGET),
    .BUSY             (BUSY)
  );

  // {sel S/C/E, we, wdata, redirect, target, busy}
  logic [69:0] w_obs;
  assign w_obs = {MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC,
                  CP0_WE, CP0_WDATA, PC_REDIRECT, PC_TARGET, BUSY};

  logic [69:0] q_val[$];
  string       q_tag[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic exp_out(input string tag, input logic [2:0] sel, input logic we,
                         input logic [31:0] wd, input logic rd, input logic [31:0] tg,
                         input logic busy);
    q_val.push_back({sel, we, wd, rd, tg, busy});
    q_tag.push_back(tag);
  endtask

  task automatic exp_idle(input string tag);
    exp_out(tag, SEL_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic check();
    logic [69:0] e;
    string       t;
    n_cmp++;
    assert (q_val.size() != 0) else begin
      n_bad++;
      $error("FAIL scoreboard_underflow observed=%h required=<entry>", w_obs);
    end
    if (q_val.size() != 0) begin
      e = q_val.pop_front();
      t = q_tag.pop_front();
      assert (w_obs === e) else begin
        n_bad++;
        $error("FAIL %s observed=%h required=%h", t, w_obs, e);
      end
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
    check();
  endtask

  initial begin
    RST = 1'b1; EXC_REQ = 1'b0; EXC_CODE = 5'd0; ERET_REQ = 1'b0;
    PC_IN = 32'd0; STATUS_IN = 32'd0; EPC_IN = 32'd0;
    #2;
    exp_idle("reset_state"); check();
    @(negedge CLK);
    RST = 1'b0;
    exp_idle("idle_after_reset"); cycle();

    // Syscall
    EXC_REQ = 1'b1; EXC_CODE = 5'd8; PC_IN = 32'h00400020; STATUS_IN = 32'h0000000F;
    exp_out("sys_status", SEL_S, 1'b1, 32'h000001E0, 1'b0, 32'd0, 1'b1); cycle();
    EXC_REQ = 1'b0;
    exp_out("sys_cause", SEL_C, 1'b1, 32'h00000020, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("sys_epc", SEL_E, 1'b1, 32'h00400020, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("sys_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, VEC, 1'b1); cycle();
    exp_idle("sys_done"); cycle();

    // ERET
    ERET_REQ = 1'b1; STATUS_IN = 32'h000001E0; EPC_IN = 32'h00400020;
    exp_out("eret_status", SEL_S, 1'b1, 32'h0000000F, 1'b0, 32'd0, 1'b1); cycle();
    ERET_REQ = 1'b0;
    exp_out("eret_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, 32'h00400020, 1'b1); cycle();
    exp_idle("eret_done"); cycle();

    // Simultaneous requests, then requests held while busy
    EXC_REQ = 1'b1; ERET_REQ = 1'b1; EXC_CODE = 5'd9; PC_IN = 32'h00400100;
    STATUS_IN = 32'h12345678; EPC_IN = 32'h0BADF00D;
    exp_out("both_status", SEL_S, 1'b1, 32'h468ACF00, 1'b0, 32'd0, 1'b1); cycle();
    EXC_CODE = 5'd13; PC_IN = 32'hDEAD0000; STATUS_IN = 32'h0;
    exp_out("both_cause", SEL_C, 1'b1, 32'h00000024, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("both_epc", SEL_E, 1'b1, 32'h00400100, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("both_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, VEC, 1'b1); cycle();
    EXC_REQ = 1'b0; ERET_REQ = 1'b0;
    exp_idle("busy_req_dropped"); cycle();
    exp_idle("busy_req_dropped2"); cycle();

    // Reset during X_CAUSE
    EXC_REQ = 1'b1; EXC_CODE = 5'd13; PC_IN = 32'h00400200; STATUS_IN = 32'h00000001;
    exp_out("teq_status", SEL_S, 1'b1, 32'h00000020, 1'b0, 32'd0, 1'b1); cycle();
    EXC_REQ = 1'b0;
    exp_out("teq_cause", SEL_C, 1'b1, 32'h00000034, 1'b0, 32'd0, 1'b1); cycle();
    #2 RST = 1'b1;
    #1 exp_idle("rst_async"); check();
    @(negedge CLK);
    exp_idle("rst_held"); check();
    RST = 1'b0;
    exp_idle("rst_no_epc"); cycle();
    exp_idle("rst_no_jump"); cycle();
    exp_idle("rst_idle"); cycle();

    // ERET after reset: all-ones Status
    ERET_REQ = 1'b1; STATUS_IN = 32'hFFFFFFFF; EPC_IN = 32'h80000000;
    exp_out("eret2_status", SEL_S, 1'b1, 32'h07FFFFFF, 1'b0, 32'd0, 1'b1); cycle();
    ERET_REQ = 1'b0;
    exp_out("eret2_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, 32'h80000000, 1'b1); cycle();
    exp_idle("eret2_done"); cycle();

`ifdef CP0_EXC_MASK_EN
    EXC_REQ = 1'b1; EXC_CODE = 5'd8; PC_IN = 32'h00400300; STATUS_IN = 32'h0000000D;
    exp_idle("mask_sys_blocked"); cycle();
    EXC_CODE = 5'd4; STATUS_IN = 32'h0000000F;
    exp_idle("mask_unlisted_blocked"); cycle();
    EXC_CODE = 5'd9; STATUS_IN = 32'h0000000D;
    exp_out("mask_brk_status", SEL_S, 1'b1, 32'h000001A0, 1'b0, 32'd0, 1'b1); cycle();
    EXC_REQ = 1'b0;
    exp_out("mask_brk_cause", SEL_C, 1'b1, 32'h00000024, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("mask_brk_epc", SEL_E, 1'b1, 32'h00400300, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("mask_brk_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, VEC, 1'b1); cycle();
    exp_idle("mask_brk_done"); cycle();
`else
    EXC_REQ = 1'b1; EXC_CODE = 5'd4; PC_IN = 32'h00400300; STATUS_IN = 32'h0000000C;
    exp_out("nomask_status", SEL_S, 1'b1, 32'h00000180, 1'b0, 32'd0, 1'b1); cycle();
    EXC_REQ = 1'b0;
    exp_out("nomask_cause", SEL_C, 1'b1, 32'h00000010, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("nomask_epc", SEL_E, 1'b1, 32'h00400300, 1'b0, 32'd0, 1'b1); cycle();
    exp_out("nomask_jump", SEL_NONE, 1'b0, 32'd0, 1'b1, VEC, 1'b1); cycle();
    exp_idle("nomask_done"); cycle();
`endif

    n_cmp++;
    assert (q_val.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", q_val.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
